// File: rtl/sc_pkg.sv
// Shared definitions for the stochastic-computing stages.
package sc_pkg;

    localparam int unsigned SC_WINDOW_LOG2_DEFAULT = 8;

    // Conversion FSM states; DONE is only reached in single-shot builds
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } sc_conv_state_t;

endpackage

// File: rtl/sc_window_timer.sv
// W-bit accepted-sample counter; last_c flags the final sample slot of a window.
module sc_window_timer #(
    parameter int unsigned W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic last_c
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Clear wins over enable so a window restart lands on zero
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + W'(1);
        end
    end

    // Sample counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last_c = (count_q == '1);

endmodule

// File: rtl/sc_stream_to_binary.sv
// Counts ones of a stochastic bitstream over 2^WINDOW_LOG2 accepted samples
// and presents a saturated W-bit result with a done pulse.
// Build option: SC_CONTINUOUS_EN makes start a level run-enable with
// back-to-back windows; otherwise each start runs one window (single-shot).
module sc_stream_to_binary
    import sc_pkg::*;
#(
    parameter int unsigned WINDOW_LOG2 = SC_WINDOW_LOG2_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [WINDOW_LOG2-1:0] value,
    output logic                   valid
);

    localparam int unsigned W = WINDOW_LOG2;

    sc_conv_state_t state_q, state_d;
    logic [W:0]     ones_q, ones_d;
    logic [W:0]     ones_sum;
    logic [W-1:0]   value_q, value_d;
    logic           valid_q, valid_d;
    logic           done_q, done_d;
    logic           busy_q;
    logic           timer_clr;
    logic           timer_en;
    logic           last_c;

    sc_window_timer #(
        .W(W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (timer_clr),
        .en_i   (timer_en),
        .last_c (last_c)
    );

    assign ones_sum = ones_q + (W+1)'(bit_in);

    // Next-state, counter control and result capture
    always_comb begin
        state_d   = state_q;
        ones_d    = ones_q;
        value_d   = value_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        timer_clr = 1'b0;
        timer_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ACCUM;
                    ones_d    = '0;
                    timer_clr = 1'b1;
                end
            end
            ACCUM: begin
                if (bit_valid) begin
                    timer_en = 1'b1;
                    ones_d   = ones_sum;
                    if (last_c) begin
                        done_d  = 1'b1;
                        valid_d = 1'b1;
                        // A full window of ones (2^W) does not fit in W bits
                        value_d = ones_sum[W] ? '1 : ones_sum[W-1:0];
                        ones_d  = '0;
`ifdef SC_CONTINUOUS_EN
                        if (start) begin
                            timer_clr = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = DONE;
`endif
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ones_q  <= '0;
            value_q <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ones_q  <= ones_d;
            value_q <= value_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= (state_d == ACCUM);
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign value = value_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_sc_stream_to_binary.sv
// Directed bench for sc_stream_to_binary with a 16-sample window.
module tb_sc_stream_to_binary;

    logic       clk;
    logic       rst_n;
    logic       bit_in;
    logic       bit_valid;
    logic       start;
    logic       busy;
    logic       done;
    logic [3:0] value;
    logic       valid;

    int checks;
    int failures;
    int prev_val;

    sc_stream_to_binary #(
        .WINDOW_LOG2(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .value     (value),
        .valid     (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [15:0] pat;       // bit s = value of accepted sample s
        bit          tog;       // bit_valid low on even cycles
        logic        junk;      // bit_in shown while bit_valid is low
        int          exp_val;
        int          exp_done;  // cycle of done, start sampled in cycle 0
    } vec_t;

    vec_t tbl[7];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One conversion: start pulse (or held start), feed samples, watch done
    task automatic run_conv(input string name, input logic [15:0] pat, input bit tog,
                            input logic junk, input bit hold, input int exp_val,
                            input int exp_done);
        int s;
        int done_cyc;
        int ndone;
        s = 0;
        done_cyc = -1;
        ndone = 0;
        start = 1'b1;
        bit_valid = 1'b0;
        bit_in = 1'b0;
        step();
        chk({name, " busy_after_start"}, int'(busy), 1);
        for (int cyc = 1; cyc <= 80; cyc++) begin
            if (done) begin
                ndone++;
                if (done_cyc < 0) begin
                    done_cyc = cyc;
                    chk({name, " value"}, int'(value), exp_val);
                    chk({name, " valid"}, int'(valid), 1);
                    chk({name, " busy_at_done"}, int'(busy), 0);
                end
            end
            if (cyc == exp_done - 1) begin
                chk({name, " value_held"}, int'(value), prev_val);
                chk({name, " busy_in_window"}, int'(busy), 1);
            end
            start = (hold && (done_cyc < 0 || cyc <= done_cyc)) ? 1'b1 : 1'b0;
            if (tog && (cyc % 2 == 0)) begin
                bit_valid = 1'b0;
                bit_in = junk;
            end else if (s < 16) begin
                bit_valid = 1'b1;
                bit_in = pat[s];
                s++;
            end else begin
                bit_valid = 1'b0;
                bit_in = junk;
            end
            step();
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end
        bit_valid = 1'b0;
        start = 1'b0;
        chk({name, " done_cycle"}, done_cyc, exp_done);
        chk({name, " done_count"}, ndone, 1);
        chk({name, " busy_idle"}, int'(busy), 0);
        prev_val = exp_val;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        prev_val = 0;
        rst_n = 1'b0;
        bit_in = 1'b0;
        bit_valid = 1'b0;
        start = 1'b0;

        tbl[0] = '{"all_ones",   16'hFFFF, 1'b0, 1'b0, 15, 17};
        tbl[1] = '{"alt_10",     16'h5555, 1'b0, 1'b0,  8, 17};
        tbl[2] = '{"all_zeros",  16'h0000, 1'b0, 1'b1,  0, 17};
        tbl[3] = '{"fifteen",    16'h7FFF, 1'b0, 1'b0, 15, 17};
        tbl[4] = '{"single_one", 16'h0001, 1'b0, 1'b0,  1, 17};
        tbl[5] = '{"tog_ones",   16'hFFFF, 1'b1, 1'b1, 15, 32};
        tbl[6] = '{"tog_stall",  16'h0000, 1'b1, 1'b1,  0, 32};

        repeat (3) step();
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset value", int'(value), 0);
        chk("reset valid", int'(valid), 0);
        rst_n = 1'b1;
        step();
        chk("idle valid", int'(valid), 0);

        for (int i = 0; i < 7; i++) begin
            run_conv(tbl[i].name, tbl[i].pat, tbl[i].tog, tbl[i].junk, 1'b0,
                     tbl[i].exp_val, tbl[i].exp_done);
        end

        // Reset mid-window after 7 accepted samples
        start = 1'b1;
        step();
        start = 1'b0;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        repeat (7) step();
        chk("mid busy_before_rst", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst busy", int'(busy), 0);
        chk("mid_rst done", int'(done), 0);
        chk("mid_rst value", int'(value), 0);
        chk("mid_rst valid", int'(valid), 0);
        bit_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        prev_val = 0;
        run_conv("after_rst_1100", 16'h3333, 1'b0, 1'b0, 1'b0, 8, 17);

`ifndef SC_CONTINUOUS_EN
        // Held start yields one conversion; a fresh start yields a second
        run_conv("held_start", 16'hFFFF, 1'b0, 1'b0, 1'b1, 15, 17);
        run_conv("second_start", 16'h5555, 1'b0, 1'b0, 1'b0, 8, 17);
`else
        begin
            int s;
            int nd;
            int dc[3];
            s = 0;
            nd = 0;
            start = 1'b1;
            bit_valid = 1'b0;
            step();
            for (int cyc = 1; cyc <= 49; cyc++) begin
                chk($sformatf("cont busy c%0d", cyc), int'(busy), 1);
                if (done) begin
                    if (nd < 3) dc[nd] = cyc;
                    nd++;
                    chk($sformatf("cont value c%0d", cyc), int'(value), 4);
                end
                if (s < 48) begin
                    bit_valid = 1'b1;
                    bit_in = (s % 4 == 0) ? 1'b1 : 1'b0;
                    s++;
                end else begin
                    bit_valid = 1'b0;
                end
                step();
            end
            chk("cont done_count", nd, 3);
            if (nd >= 3) begin
                chk("cont first_done", dc[0], 17);
                chk("cont spacing1", dc[1] - dc[0], 16);
                chk("cont spacing2", dc[2] - dc[1], 16);
            end
            start = 1'b0;
            rst_n = 1'b0;
            step();
            rst_n = 1'b1;
            step();
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
